// File: rtl/motor_cmd_pkg.sv
// Purpose: shared constants and enums for the UART motor command decoder.
//   SYNC_BYTE / BCAST_CH : framing byte and broadcast channel id
//   state_e              : frame parser states
//   err_e                : rejection cause reported on err_code
package motor_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'h53;
  localparam logic [7:0] BCAST_CH  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CHAN = 2'd1,
    POS  = 2'd2,
    CSUM = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_CSUM = 2'd1,
    ERR_CH   = 2'd2,
    ERR_TMO  = 2'd3
  } err_e;

endpackage

// File: rtl/cmd_timeout_timer.sv
// Purpose: inter-byte idle timer. Counts enabled cycles since the last clear and
//   pulses expire_o for one cycle once TIMEOUT_CYC idle cycles have elapsed.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : restart the count (takes priority over en_i)
//   en_i          : count this cycle
//   expire_o      : registered one-cycle expiry pulse
module cmd_timeout_timer #(
  parameter int unsigned TIMEOUT_CYC = 868
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire_q, expire_d;

  // Saturating count; expiry is flagged as the count reaches TIMEOUT_CYC.
  always_comb begin
    cnt_d    = cnt_q;
    expire_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d    = cnt_q + CNT_W'(1);
      expire_d = (cnt_q == CNT_LAST);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/uart_motor_cmd_decoder.sv
// Purpose: parse SYNC/CH/POS.../CSUM frames from the UART byte stream and load the
//   per-channel position registers with a one-cycle update strobe.
// Ports:
//   CLK_10MHZ, RST_N      : clock, async active-low reset
//   rx_valid, rx_data     : received byte strobe and data
//   pos_out               : channel k position at [k*POS_W +: POS_W]
//   pos_strobe            : one-cycle per-channel update pulse
//   frame_ok, frame_err   : one-cycle accept / reject pulses
//   err_code              : cause of the last rejection (sticky)
//   busy                  : a frame is open
module uart_motor_cmd_decoder
  import motor_cmd_pkg::*;
#(
  parameter int unsigned NUM_CH      = 12,
  parameter int unsigned POS_W       = 24,
  parameter int unsigned TIMEOUT_CYC = 868
) (
  input  logic                    CLK_10MHZ,
  input  logic                    RST_N,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  output logic [NUM_CH*POS_W-1:0] pos_out,
  output logic [NUM_CH-1:0]       pos_strobe,
  output logic                    frame_ok,
  output logic                    frame_err,
  output logic [1:0]              err_code,
  output logic                    busy
);

  localparam int unsigned POS_BYTES = POS_W / 8;
  localparam int unsigned BCNT_W    = 2;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(POS_BYTES - 1);
  localparam logic [7:0]        CH_LIMIT  = 8'(NUM_CH);

  if (((POS_W % 8) != 0) || (POS_BYTES < 1) || (POS_BYTES > 4) ||
      (NUM_CH < 1) || (NUM_CH > 254)) begin : g_bad_params
    $error("uart_motor_cmd_decoder: unsupported NUM_CH/POS_W");
  end

  state_e              state_q, state_d;
  logic [7:0]          chan_q, chan_d;
  logic [7:0]          csum_q, csum_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [POS_W-1:0]    shadow_q, shadow_d;
  logic [POS_W-1:0]    pos_q [NUM_CH];
  logic [POS_W-1:0]    pos_d [NUM_CH];
  logic [NUM_CH-1:0]   strobe_q, strobe_d;
  logic                ok_q, ok_d;
  logic                err_q, err_d;
  logic [1:0]          code_q, code_d;
  logic                busy_q, busy_d;
  logic                tmo_expire;

  cmd_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk_i   (CLK_10MHZ),
    .rst_ni  (RST_N),
    .clr_i   (rx_valid || (state_q == IDLE)),
    .en_i    (state_q != IDLE),
    .expire_o(tmo_expire)
  );

  // Frame parser: next state, shadow/checksum accumulation and register bank writes.
  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    csum_d   = csum_q;
    bcnt_d   = bcnt_q;
    shadow_d = shadow_q;
    pos_d    = pos_q;
    strobe_d = '0;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;

    unique case (state_q)
      IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) state_d = CHAN;
      end
      CHAN: begin
        if (rx_valid) begin
          chan_d  = rx_data;
          csum_d  = rx_data;
          bcnt_d  = '0;
          state_d = POS;
        end
      end
      POS: begin
        // Payload bytes are data even when they equal SYNC_BYTE.
        if (rx_valid) begin
          shadow_d = (shadow_q << 8) | POS_W'(rx_data);
          csum_d   = csum_q ^ rx_data;
          if (bcnt_q == BCNT_LAST) state_d = CSUM;
          else                     bcnt_d  = bcnt_q + BCNT_W'(1);
        end
      end
      CSUM: begin
        if (rx_valid) begin
          state_d = IDLE;
          if (rx_data != csum_q) begin
            err_d  = 1'b1;
            code_d = ERR_CSUM;
          end else if (chan_q < CH_LIMIT) begin
            ok_d = 1'b1;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
              if (chan_q == 8'(k)) begin
                pos_d[k]    = shadow_q;
                strobe_d[k] = 1'b1;
              end
            end
          end else if (chan_q == BCAST_CH) begin
            ok_d     = 1'b1;
            strobe_d = '1;
            for (int unsigned k = 0; k < NUM_CH; k++) pos_d[k] = shadow_q;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_CH;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A byte arriving in the expiry cycle wins over the timeout.
    if (tmo_expire && !rx_valid && (state_q != IDLE)) begin
      state_d = IDLE;
      err_d   = 1'b1;
      code_d  = ERR_TMO;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK_10MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      chan_q   <= '0;
      csum_q   <= '0;
      bcnt_q   <= '0;
      shadow_q <= '0;
      for (int unsigned k = 0; k < NUM_CH; k++) pos_q[k] <= '0;
      strobe_q <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      csum_q   <= csum_d;
      bcnt_q   <= bcnt_d;
      shadow_q <= shadow_d;
      pos_q    <= pos_d;
      strobe_q <= strobe_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      code_q   <= code_d;
      busy_q   <= busy_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_pos_out
    assign pos_out[k*POS_W +: POS_W] = pos_q[k];
  end

  assign pos_strobe = strobe_q;
  assign frame_ok   = ok_q;
  assign frame_err  = err_q;
  assign err_code   = code_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_motor_cmd_decoder.sv
// Purpose: self-checking bench for uart_motor_cmd_decoder. Expected output events are
//   queued as frames are driven; a monitor records every strobe/ok/err cycle and each
//   test pairs observed events with expected ones.
module tb_uart_motor_cmd_decoder;

  localparam int NUM_CH = 12;
  localparam int POS_W  = 24;
  localparam int TMO    = 868;
  localparam int FLAT   = NUM_CH * POS_W;

  typedef struct packed {
    logic [NUM_CH-1:0] strobe;
    logic              ok;
    logic              err;
    logic [1:0]        code;
    logic [FLAT-1:0]   pos;
  } ev_t;

  logic              clk;
  logic              rst_n;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic [FLAT-1:0]   pos_out;
  logic [NUM_CH-1:0] pos_strobe;
  logic              frame_ok;
  logic              frame_err;
  logic [1:0]        err_code;
  logic              busy;

  ev_t               exp_q[$];
  ev_t               obs_q[$];
  logic [POS_W-1:0]  model [NUM_CH];
  logic [1:0]        model_code;
  int                checks;
  int                failures;

  uart_motor_cmd_decoder #(
    .NUM_CH(NUM_CH), .POS_W(POS_W), .TIMEOUT_CYC(TMO)
  ) dut (
    .CLK_10MHZ (clk),
    .RST_N     (rst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .pos_out   (pos_out),
    .pos_strobe(pos_strobe),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Record every cycle that carries a strobe or frame result.
  always @(negedge clk) begin
    if (rst_n && ((pos_strobe != '0) || frame_ok || frame_err)) begin
      ev_t o;
      o.strobe = pos_strobe;
      o.ok     = frame_ok;
      o.err    = frame_err;
      o.code   = err_code;
      o.pos    = pos_out;
      obs_q.push_back(o);
    end
  end

  initial begin
    #(100 * 30000);
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  function automatic logic [FLAT-1:0] flat_model();
    logic [FLAT-1:0] f;
    f = '0;
    for (int k = 0; k < NUM_CH; k++) f[k*POS_W +: POS_W] = model[k];
    return f;
  endfunction

  function automatic logic [7:0] xsum(input logic [7:0] ch, input logic [POS_W-1:0] p);
    logic [7:0] s;
    s = ch;
    for (int i = 0; i < POS_W / 8; i++) s = s ^ p[i*8 +: 8];
    return s;
  endfunction

  function automatic string fmt(input ev_t e);
    return $sformatf("strobe=%h ok=%b err=%b code=%0d pos=%h", e.strobe, e.ok, e.err, e.code, e.pos);
  endfunction

  // Reference outcome of one complete frame; updates the model and queues the event.
  task automatic expect_frame(input logic [7:0] ch, input logic [POS_W-1:0] p, input logic [7:0] cs);
    ev_t e;
    e = '0;
    if (cs != xsum(ch, p)) begin
      e.err = 1'b1; model_code = 2'd1;
    end else if (int'(ch) < NUM_CH) begin
      model[int'(ch)] = p; e.strobe[int'(ch)] = 1'b1; e.ok = 1'b1;
    end else if (ch == 8'hFF) begin
      for (int k = 0; k < NUM_CH; k++) model[k] = p;
      e.strobe = '1; e.ok = 1'b1;
    end else begin
      e.err = 1'b1; model_code = 2'd2;
    end
    e.code = model_code;
    e.pos  = flat_model();
    exp_q.push_back(e);
  endtask

  task automatic expect_timeout();
    ev_t e;
    e = '0;
    model_code = 2'd3;
    e.err  = 1'b1;
    e.code = model_code;
    e.pos  = flat_model();
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; leaves rx_valid low at the following posedge+1.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [7:0] ch, input logic [POS_W-1:0] p,
                            input logic [7:0] cs, input bit gap_after);
    expect_frame(ch, p, cs);
    send_byte(8'h53); idle(1);
    send_byte(ch);    idle(1);
    for (int i = POS_W / 8 - 1; i >= 0; i--) begin
      send_byte(p[i*8 +: 8]); idle(1);
    end
    send_byte(cs);
    if (gap_after) idle(1);
  endtask

  // Waits (bounded) for the next observed event and pairs it with the next expected one.
  task automatic pop_pair(output ev_t o, output ev_t e, output bit got);
    got = 1'b0; o = '0; e = '0;
    for (int i = 0; i < 40 && obs_q.size() == 0; i++) begin @(posedge clk); #1; end
    if (obs_q.size() != 0) o = obs_q.pop_front();
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      got = (o != '0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    model_code = 2'd0;
    for (int k = 0; k < NUM_CH; k++) model[k] = '0;
    idle(3);
    checks++;
    if ({pos_out, pos_strobe, frame_ok, frame_err, err_code, busy} !== '0) begin
      failures++;
      $display("FAIL reset_held: got pos=%h strobe=%h ok=%b err=%b code=%0d busy=%b, need all 0",
               pos_out, pos_strobe, frame_ok, frame_err, err_code, busy);
    end
    rst_n = 1'b1;
    idle(2);
    checks++;
    if ({pos_out, pos_strobe, frame_ok, frame_err, err_code, busy} !== '0) begin
      failures++;
      $display("FAIL reset_release: got pos=%h strobe=%h ok=%b err=%b code=%0d busy=%b, need all 0",
               pos_out, pos_strobe, frame_ok, frame_err, err_code, busy);
    end
  endtask

  task automatic test_good_frame();
    ev_t o, e; bit got;
    // 03^12^34^56 = 73
    send_frame(8'h03, 24'h123456, 8'h73, 1'b0);
    checks++;
    if ((pos_strobe !== 12'h008) || (frame_ok !== 1'b1) || (pos_out[3*POS_W +: POS_W] !== 24'h123456)) begin
      failures++;
      $display("FAIL good_latency: got strobe=%h ok=%b pos3=%h, need strobe=008 ok=1 pos3=123456",
               pos_strobe, frame_ok, pos_out[3*POS_W +: POS_W]);
    end
    pop_pair(o, e, got);
    checks++;
    if (!got || o !== e) begin failures++; $display("FAIL good_frame: got %s need %s", fmt(o), fmt(e)); end
    idle(3);
    checks++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL good_leftover: got obs=%0d exp=%0d need 0/0", obs_q.size(), exp_q.size());
      obs_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_bad_csum();
    ev_t o, e; bit got;
    send_frame(8'h03, 24'h123456, 8'h70, 1'b1);
    send_frame(8'h03, 24'h654321, 8'h71, 1'b1);
    for (int i = 0; i < 2; i++) begin
      pop_pair(o, e, got);
      checks++;
      if (!got || o !== e) begin failures++; $display("FAIL bad_csum%0d: got %s need %s", i, fmt(o), fmt(e)); end
    end
    idle(3);
    checks++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bad_csum_leftover: got obs=%0d exp=%0d need 0/0", obs_q.size(), exp_q.size());
      obs_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_broadcast();
    ev_t o, e; bit got;
    send_frame(8'hFF, 24'h000010, 8'hEF, 1'b1);
    pop_pair(o, e, got);
    checks++;
    if (!got || o !== e) begin failures++; $display("FAIL broadcast: got %s need %s", fmt(o), fmt(e)); end
    send_frame(8'h0C, 24'h000000, 8'h0C, 1'b1);
    pop_pair(o, e, got);
    checks++;
    if (!got || o !== e) begin failures++; $display("FAIL bad_channel: got %s need %s", fmt(o), fmt(e)); end
    idle(3);
    checks++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL broadcast_leftover: got obs=%0d exp=%0d need 0/0", obs_q.size(), exp_q.size());
      obs_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_timeout();
    ev_t o, e; bit got;
    expect_timeout();
    send_byte(8'h53); idle(1);
    send_byte(8'h05); idle(1);
    send_byte(8'hAA);
    idle(TMO);
    checks++;
    if ((busy !== 1'b1) || (frame_err !== 1'b0)) begin
      failures++;
      $display("FAIL tmo_early: got busy=%b err=%b, need busy=1 err=0", busy, frame_err);
    end
    idle(1);
    checks++;
    if ((busy !== 1'b0) || (frame_err !== 1'b1) || (err_code !== 2'd3)) begin
      failures++;
      $display("FAIL tmo_edge: got busy=%b err=%b code=%0d, need busy=0 err=1 code=3", busy, frame_err, err_code);
    end
    pop_pair(o, e, got);
    checks++;
    if (!got || o !== e) begin failures++; $display("FAIL timeout: got %s need %s", fmt(o), fmt(e)); end
    send_frame(8'h05, 24'h0A0B0C, xsum(8'h05, 24'h0A0B0C), 1'b1);
    pop_pair(o, e, got);
    checks++;
    if (!got || o !== e) begin failures++; $display("FAIL after_timeout: got %s need %s", fmt(o), fmt(e)); end
    idle(3);
    checks++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL timeout_leftover: got obs=%0d exp=%0d need 0/0", obs_q.size(), exp_q.size());
      obs_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_garbage_sync();
    ev_t o, e; bit got;
    send_byte(8'h00); idle(1);
    send_byte(8'h41); idle(1);
    checks++;
    if ((busy !== 1'b0) || (obs_q.size() != 0)) begin
      failures++;
      $display("FAIL garbage: got busy=%b events=%0d, need busy=0 events=0", busy, obs_q.size());
    end
    send_frame(8'h01, 24'h535353, 8'h52, 1'b1);
    pop_pair(o, e, got);
    checks++;
    if (!got || o !== e) begin failures++; $display("FAIL payload_sync: got %s need %s", fmt(o), fmt(e)); end
    send_byte(8'h53); idle(1);
    send_byte(8'h02); idle(1);
    send_byte(8'h11);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL mid_frame_busy: got busy=%b need 1", busy); end
    #20 rst_n = 1'b0;
    #1;
    for (int k = 0; k < NUM_CH; k++) model[k] = '0;
    model_code = 2'd0;
    checks++;
    if ({pos_out, pos_strobe, frame_ok, frame_err, err_code, busy} !== '0) begin
      failures++;
      $display("FAIL reset_mid_frame: got pos=%h strobe=%h ok=%b err=%b code=%0d busy=%b, need all 0",
               pos_out, pos_strobe, frame_ok, frame_err, err_code, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3);
    checks++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL garbage_leftover: got obs=%0d exp=%0d need 0/0", obs_q.size(), exp_q.size());
      obs_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_coincidence();
    ev_t o, e; bit got;
    expect_frame(8'h07, 24'h010203, xsum(8'h07, 24'h010203));
    send_byte(8'h53); idle(1);
    send_byte(8'h07); idle(1);
    send_byte(8'h01);
    idle(TMO);          // next byte lands in the expiry cycle
    send_byte(8'h02); idle(1);
    send_byte(8'h03); idle(1);
    send_byte(xsum(8'h07, 24'h010203)); idle(1);
    pop_pair(o, e, got);
    checks++;
    if (!got || o !== e) begin failures++; $display("FAIL coincidence: got %s need %s", fmt(o), fmt(e)); end
    idle(3);
    checks++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL coincidence_leftover: got obs=%0d exp=%0d need 0/0", obs_q.size(), exp_q.size());
      obs_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    ev_t o, e; bit got;
    send_frame(8'h00, 24'h000001, xsum(8'h00, 24'h000001), 1'b0);
    send_frame(8'h0B, 24'hABCDEF, xsum(8'h0B, 24'hABCDEF), 1'b1);
    for (int i = 0; i < 2; i++) begin
      pop_pair(o, e, got);
      checks++;
      if (!got || o !== e) begin failures++; $display("FAIL back_to_back%0d: got %s need %s", i, fmt(o), fmt(e)); end
    end
    idle(3);
    checks++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL back_to_back_leftover: got obs=%0d exp=%0d need 0/0", obs_q.size(), exp_q.size());
      obs_q.delete(); exp_q.delete();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_broadcast();
    test_timeout();
    test_garbage_sync();
    test_coincidence();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
